// File: rtl/wlo_pkg.sv
// Shared state encoding, config field type and default widths for the WLO run sequencer.
package wlo_pkg;

  localparam int A_W_DEF    = 14;
  localparam int B_W_DEF    = 14;
  localparam int C_W_DEF    = 29;
  localparam int FRAC_W_DEF = 8;
  localparam int LAT_DEF    = 3;
  localparam int CNT_W_DEF  = 16;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } seq_state_e;

  typedef logic [FRAC_W_DEF-1:0] frac_t;

endpackage

// File: rtl/wlo_valid_pipe.sv
// Tag shift register: each accept bit travels DEPTH stages so results can be realigned with
// the fixed-latency datapath; any_valid reports tags still in flight.
module wlo_valid_pipe #(
  parameter int DEPTH = 4
) (
  input  logic clk,
  input  logic rstn,
  input  logic in_valid,
  output logic out_valid,
  output logic any_valid
);

  logic [DEPTH:0] chain;

  assign chain[0] = in_valid;

  for (genvar gi = 0; gi < DEPTH; gi++) begin : g_stage
    logic tag_reg;

    always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
        tag_reg <= 1'b0;
      end else begin
        tag_reg <= chain[gi];
      end
    end

    assign chain[gi+1] = tag_reg;
  end

  assign out_valid = chain[DEPTH];
  assign any_valid = |chain[DEPTH:1];

endmodule

// File: rtl/wlo_run_sequencer.sv
// Sequences one WLO run through the fixed-latency a*b->c datapath and realigns its results.
// Optional peak |c| tracking is compiled in when WLO_PEAK_EN is defined.
module wlo_run_sequencer
  import wlo_pkg::*;
#(
  parameter int A_W    = A_W_DEF,
  parameter int B_W    = B_W_DEF,
  parameter int C_W    = C_W_DEF,
  parameter int FRAC_W = FRAC_W_DEF,
  parameter int LAT    = LAT_DEF,
  parameter int CNT_W  = CNT_W_DEF
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              cfg_valid,
  output logic              cfg_ready,
  input  logic [FRAC_W-1:0] cfg_frac_a,
  input  logic [FRAC_W-1:0] cfg_frac_b,
  input  logic [FRAC_W-1:0] cfg_frac_c,
  input  logic [CNT_W-1:0]  cfg_len,
  input  logic              s_valid,
  output logic              s_ready,
  input  logic [A_W-1:0]    s_a,
  input  logic [B_W-1:0]    s_b,
  output logic [FRAC_W-1:0] dp_num_frac_a,
  output logic [FRAC_W-1:0] dp_num_frac_b,
  output logic [FRAC_W-1:0] dp_num_frac_c,
  output logic [A_W-1:0]    dp_a,
  output logic [B_W-1:0]    dp_b,
  input  logic [C_W-1:0]    dp_c,
  output logic              m_valid,
  output logic [C_W-1:0]    m_c,
  output logic              busy,
  output logic              done,
  output logic [C_W-1:0]    peak_abs
);

  seq_state_e state_reg, state_next;

  logic              out_en_reg;
  logic [CNT_W-1:0]  remaining_reg;
  logic [FRAC_W-1:0] frac_a_reg, frac_b_reg, frac_c_reg;
  logic [A_W-1:0]    dp_a_reg;
  logic [B_W-1:0]    dp_b_reg;
  logic              m_valid_reg;
  logic [C_W-1:0]    m_c_reg;

  logic cfg_hs;
  logic accept;
  logic tag_last;
  logic tag_any;

  assign cfg_hs = cfg_valid & cfg_ready;
  assign accept = s_valid & s_ready;

  // State register
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  // Next-state logic
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE: begin
        if (cfg_hs) begin
          state_next = (cfg_len == '0) ? DONE : RUN;
        end
      end
      RUN: begin
        if (accept && (remaining_reg == CNT_W'(1))) begin
          state_next = DRAIN;
        end
      end
      DRAIN: begin
        // Last result is on m_valid this cycle and nothing is left behind it.
        if (!tag_any && m_valid_reg) begin
          state_next = DONE;
        end
      end
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Output logic; out_en_reg keeps cfg_ready low until one cycle after reset release.
  always_comb begin
    cfg_ready = 1'b0;
    s_ready   = 1'b0;
    busy      = 1'b0;
    done      = 1'b0;
    case (state_reg)
      IDLE:    cfg_ready = out_en_reg;
      RUN: begin
        busy    = 1'b1;
        s_ready = (remaining_reg != '0);
      end
      DRAIN:   busy = 1'b1;
      DONE: begin
        busy = 1'b1;
        done = 1'b1;
      end
      default: busy = 1'b0;
    endcase
  end

  // Run bookkeeping and latched config
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      out_en_reg    <= 1'b0;
      remaining_reg <= '0;
      frac_a_reg    <= '0;
      frac_b_reg    <= '0;
      frac_c_reg    <= '0;
    end else begin
      out_en_reg <= 1'b1;
      if (cfg_hs) begin
        remaining_reg <= cfg_len;
        frac_a_reg    <= cfg_frac_a;
        frac_b_reg    <= cfg_frac_b;
        frac_c_reg    <= cfg_frac_c;
      end else if (accept) begin
        remaining_reg <= remaining_reg - CNT_W'(1);
      end
    end
  end

  // Operand registers hold their last value between accepts.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      dp_a_reg <= '0;
      dp_b_reg <= '0;
    end else if (accept) begin
      dp_a_reg <= s_a;
      dp_b_reg <= s_b;
    end
  end

  // Stage count LAT+1 covers the operand register plus the datapath latency.
  wlo_valid_pipe #(
    .DEPTH (LAT + 1)
  ) u_tag_pipe (
    .clk       (clk),
    .rstn      (rstn),
    .in_valid  (accept),
    .out_valid (tag_last),
    .any_valid (tag_any)
  );

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      m_valid_reg <= 1'b0;
      m_c_reg     <= '0;
    end else begin
      m_valid_reg <= tag_last;
      if (tag_last) begin
        m_c_reg <= dp_c;
      end
    end
  end

`ifdef WLO_PEAK_EN
  logic [C_W-1:0] peak_reg;
  logic [C_W-1:0] m_abs;

  // Two's complement magnitude; the most negative code saturates to the largest positive.
  always_comb begin
    m_abs = m_c_reg;
    if (m_c_reg[C_W-1]) begin
      if (m_c_reg == {1'b1, {(C_W-1){1'b0}}}) begin
        m_abs = {1'b0, {(C_W-1){1'b1}}};
      end else begin
        m_abs = -m_c_reg;
      end
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      peak_reg <= '0;
    end else if (cfg_hs) begin
      peak_reg <= '0;
    end else if (m_valid_reg && (m_abs > peak_reg)) begin
      peak_reg <= m_abs;
    end
  end

  assign peak_abs = peak_reg;
`else
  assign peak_abs = '0;
`endif

  assign dp_num_frac_a = frac_a_reg;
  assign dp_num_frac_b = frac_b_reg;
  assign dp_num_frac_c = frac_c_reg;
  assign dp_a          = dp_a_reg;
  assign dp_b          = dp_b_reg;
  assign m_valid       = m_valid_reg;
  assign m_c           = m_c_reg;

endmodule

// File: tb/tb_wlo_run_sequencer.sv
// Directed bench for wlo_run_sequencer: a cycle-schedule model checked every cycle plus
// hand-computed literal expectations per scenario. Honours WLO_PEAK_EN like the design.
module tb_wlo_run_sequencer;

  localparam int A_W    = 14;
  localparam int B_W    = 14;
  localparam int C_W    = 29;
  localparam int FRAC_W = 8;
  localparam int LAT    = 3;
  localparam int CNT_W  = 16;
`ifdef WLO_PEAK_EN
  localparam bit PEAK_EN = 1'b1;
`else
  localparam bit PEAK_EN = 1'b0;
`endif

  logic              clk = 1'b0;
  logic              rstn;
  logic              cfg_valid;
  logic              cfg_ready;
  logic [FRAC_W-1:0] cfg_frac_a, cfg_frac_b, cfg_frac_c;
  logic [CNT_W-1:0]  cfg_len;
  logic              s_valid;
  logic              s_ready;
  logic [A_W-1:0]    s_a;
  logic [B_W-1:0]    s_b;
  logic [FRAC_W-1:0] dp_num_frac_a, dp_num_frac_b, dp_num_frac_c;
  logic [A_W-1:0]    dp_a;
  logic [B_W-1:0]    dp_b;
  logic [C_W-1:0]    dp_c;
  logic              m_valid;
  logic [C_W-1:0]    m_c;
  logic              busy;
  logic              done;
  logic [C_W-1:0]    peak_abs;

  wlo_run_sequencer #(
    .A_W(A_W), .B_W(B_W), .C_W(C_W), .FRAC_W(FRAC_W), .LAT(LAT), .CNT_W(CNT_W)
  ) dut (
    .clk(clk), .rstn(rstn),
    .cfg_valid(cfg_valid), .cfg_ready(cfg_ready),
    .cfg_frac_a(cfg_frac_a), .cfg_frac_b(cfg_frac_b), .cfg_frac_c(cfg_frac_c),
    .cfg_len(cfg_len),
    .s_valid(s_valid), .s_ready(s_ready), .s_a(s_a), .s_b(s_b),
    .dp_num_frac_a(dp_num_frac_a), .dp_num_frac_b(dp_num_frac_b), .dp_num_frac_c(dp_num_frac_c),
    .dp_a(dp_a), .dp_b(dp_b), .dp_c(dp_c),
    .m_valid(m_valid), .m_c(m_c), .busy(busy), .done(done), .peak_abs(peak_abs)
  );

  always #5 clk = ~clk;

  // Stand-in datapath: signed a*b, LAT cycles after the registered operands.
  logic [C_W-1:0] dp_pipe [LAT];
  logic [C_W-1:0] prod;
  assign prod = $signed(dp_a) * $signed(dp_b);
  always @(posedge clk) begin
    dp_pipe[0] <= prod;
    for (int i = 1; i < LAT; i++) dp_pipe[i] <= dp_pipe[i-1];
  end
  assign dp_c = dp_pipe[LAT-1];

  int n_vec = 0;
  int n_err = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic logic [C_W-1:0] mag(input logic [C_W-1:0] v);
    longint x;
    x = longint'($signed(v));
    if (x < 0) x = -x;
    if (x > (longint'(1) << (C_W-1)) - 1) x = (longint'(1) << (C_W-1)) - 1;
    return x[C_W-1:0];
  endfunction

  // Model state: future result schedule keyed by cycle number.
  int             cyc = 0;
  logic [C_W-1:0] exp_mv [int];
  bit             run_active = 0;
  bit             ready_ok = 0;
  int             run_start, run_len, acc_cnt, done_cyc;
  logic [C_W-1:0] exp_mc_hold = '0;
  logic [C_W-1:0] exp_peak = '0;
  logic [A_W-1:0] exp_dp_a = '0;
  logic [B_W-1:0] exp_dp_b = '0;
  logic [FRAC_W-1:0] exp_fa = '0, exp_fb = '0, exp_fc = '0;

  // DUT observations for the literal checks
  int obs_mc[$];
  int obs_mv_cyc[$];
  int obs_hs_cyc = 0;
  int obs_done_cyc = 0;
  int done_cnt = 0;
  logic [C_W-1:0] obs_peak_done = '0;

  initial begin
    bit mv_e, done_e, busy_e, rdy_e, srdy_e;
    longint p;
    forever begin
      @(negedge clk);
      cyc++;
      if (!rstn) begin
        chk("rst_cfg_ready", cfg_ready, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_m_valid", m_valid, 0);
        chk("rst_m_c", m_c, 0);
        chk("rst_dp_a", dp_a, 0);
        chk("rst_s_ready", s_ready, 0);
        chk("rst_peak", peak_abs, 0);
        exp_mv.delete();
        run_active = 0; ready_ok = 0;
        exp_mc_hold = '0; exp_peak = '0; exp_dp_a = '0; exp_dp_b = '0;
        exp_fa = '0; exp_fb = '0; exp_fc = '0;
      end else begin
        mv_e = exp_mv.exists(cyc);
        if (mv_e) exp_mc_hold = exp_mv[cyc];
        done_e = run_active && (done_cyc == cyc);
        busy_e = run_active && (cyc >= run_start);
        rdy_e  = ready_ok && !run_active;
        srdy_e = busy_e && (acc_cnt < run_len);
        chk("cfg_ready", cfg_ready, rdy_e);
        chk("s_ready", s_ready, srdy_e);
        chk("busy", busy, busy_e);
        chk("done", done, done_e);
        chk("m_valid", m_valid, mv_e);
        chk("m_c", m_c, exp_mc_hold);
        chk("dp_a", dp_a, exp_dp_a);
        chk("dp_b", dp_b, exp_dp_b);
        chk("dp_frac", {dp_num_frac_a, dp_num_frac_b, dp_num_frac_c}, {exp_fa, exp_fb, exp_fc});
        chk("peak_abs", peak_abs, PEAK_EN ? exp_peak : '0);

        if (m_valid) begin
          obs_mc.push_back($signed(m_c));
          obs_mv_cyc.push_back(cyc);
        end
        if (done) begin
          done_cnt++;
          obs_done_cyc = cyc;
          obs_peak_done = peak_abs;
        end
        if (cfg_valid && cfg_ready) obs_hs_cyc = cyc;

        if (mv_e && mag(exp_mc_hold) > exp_peak) exp_peak = mag(exp_mc_hold);
        if (cfg_valid && rdy_e) begin
          run_active = 1; run_start = cyc + 1; run_len = int'(cfg_len); acc_cnt = 0;
          done_cyc = (cfg_len == 0) ? cyc + 1 : -1;
          exp_fa = cfg_frac_a; exp_fb = cfg_frac_b; exp_fc = cfg_frac_c;
          exp_peak = '0;
        end
        if (s_valid && srdy_e) begin
          p = longint'($signed(s_a)) * longint'($signed(s_b));
          exp_mv[cyc + LAT + 2] = p[C_W-1:0];
          acc_cnt++;
          exp_dp_a = s_a; exp_dp_b = s_b;
          if (acc_cnt == run_len) done_cyc = cyc + LAT + 3;
        end
        if (done_e) run_active = 0;
        ready_ok = 1;
      end
    end
  end

  int qa[$];
  int qb[$];

  task automatic start_run(input int fa, input int fb, input int fc, input int len);
    int budget;
    budget = 0;
    cfg_valid = 1'b1;
    cfg_frac_a = fa[FRAC_W-1:0]; cfg_frac_b = fb[FRAC_W-1:0]; cfg_frac_c = fc[FRAC_W-1:0];
    cfg_len = len[CNT_W-1:0];
    forever begin
      @(negedge clk);
      if (cfg_ready) break;
      budget++;
      if (budget > 200) begin
        chk("cfg_handshake_timeout", 0, 1);
        break;
      end
    end
    @(posedge clk); #1;
    cfg_valid = 1'b0;
  endtask

  task automatic feed(input int n, input bit toggle);
    int idx, k;
    idx = 0; k = 0;
    while (idx < n && k < 500) begin
      s_valid = toggle ? (k % 2 == 0) : 1'b1;
      s_a = qa[idx][A_W-1:0];
      s_b = qb[idx][B_W-1:0];
      @(negedge clk);
      if (s_valid && s_ready) idx++;
      @(posedge clk); #1;
      k++;
    end
    s_valid = 1'b0;
    if (idx < n) chk("feed_timeout", idx, n);
  endtask

  task automatic wait_done(input int d0);
    int budget;
    budget = 0;
    while (done_cnt <= d0 && budget < 300) begin
      @(posedge clk); #1;
      budget++;
    end
    if (done_cnt <= d0) chk("done_timeout", done_cnt, d0 + 1);
  endtask

  task automatic clear_obs();
    obs_mc.delete();
    obs_mv_cyc.delete();
  endtask

  initial begin
    int d0;
    rstn = 1'b0; cfg_valid = 1'b0; cfg_frac_a = '0; cfg_frac_b = '0; cfg_frac_c = '0;
    cfg_len = '0; s_valid = 1'b0; s_a = '0; s_b = '0;
    repeat (3) @(posedge clk);
    #1 rstn = 1'b1;
    repeat (2) @(posedge clk); #1;
    chk("lit_ready_after_reset", cfg_ready, 1);
    chk("lit_idle_not_busy", busy, 0);

    // Run of 4 back-to-back samples: results at accept+LAT+2, done one cycle after the last.
    clear_obs(); d0 = done_cnt;
    qa = '{1, 3, -5, 7}; qb = '{2, 4, 6, -8};
    start_run(8, 8, 10, 4);
    feed(4, 1'b0);
    wait_done(d0);
    chk("lit_r1_done_lat", obs_done_cyc - obs_hs_cyc, 10);
    chk("lit_r1_count", obs_mc.size(), 4);
    if (obs_mc.size() == 4) begin
      chk("lit_r1_c0", obs_mc[0], 2);
      chk("lit_r1_c1", obs_mc[1], 12);
      chk("lit_r1_c2", obs_mc[2], -30);
      chk("lit_r1_c3", obs_mc[3], -56);
      chk("lit_r1_first_mv", obs_mv_cyc[0] - obs_hs_cyc, 6);
    end
    chk("lit_r1_peak", obs_peak_done, PEAK_EN ? 56 : 0);
    chk("lit_r1_frac_c", dp_num_frac_c, 10);

    // Zero-length run: DONE the cycle after the handshake, datapath untouched.
    clear_obs(); d0 = done_cnt;
    start_run(1, 1, 1, 0);
    wait_done(d0);
    chk("lit_len0_done_lat", obs_done_cyc - obs_hs_cyc, 1);
    chk("lit_len0_count", obs_mc.size(), 0);
    chk("lit_len0_dp_a", dp_a, 7);

    // Gapped input 1,0,1,0,1: results mirror the accept gaps.
    clear_obs(); d0 = done_cnt;
    qa = '{2, -4, 6}; qb = '{3, 5, -7};
    start_run(5, 6, 7, 3);
    feed(3, 1'b1);
    wait_done(d0);
    chk("lit_gap_done_lat", obs_done_cyc - obs_hs_cyc, 11);
    chk("lit_gap_count", obs_mc.size(), 3);
    if (obs_mc.size() == 3) begin
      chk("lit_gap_mv0", obs_mv_cyc[0] - obs_hs_cyc, 6);
      chk("lit_gap_mv1", obs_mv_cyc[1] - obs_hs_cyc, 8);
      chk("lit_gap_mv2", obs_mv_cyc[2] - obs_hs_cyc, 10);
      chk("lit_gap_c2", obs_mc[2], -42);
    end

    // cfg_valid held through a run: second request taken on the first IDLE cycle.
    clear_obs(); d0 = done_cnt;
    qa = '{1, 2}; qb = '{1, 2};
    start_run(1, 2, 3, 2);
    cfg_valid = 1'b1; cfg_frac_a = 8'd4; cfg_frac_b = 8'd4; cfg_frac_c = 8'd4; cfg_len = 16'd1;
    feed(2, 1'b0);
    start_run(4, 4, 4, 1);
    chk("lit_held_hs_after_done", obs_hs_cyc - obs_done_cyc, 1);
    qa = '{3}; qb = '{3};
    feed(1, 1'b0);
    wait_done(d0 + 1);
    chk("lit_held_frac_a", dp_num_frac_a, 4);
    chk("lit_held_last_c", obs_mc[obs_mc.size()-1], 9);

    // Reset asserted during DRAIN: nothing in flight may surface afterwards.
    qa = '{10, 11, 12}; qb = '{1, 1, 1};
    start_run(2, 2, 2, 3);
    feed(3, 1'b0);
    clear_obs(); d0 = done_cnt;
    rstn = 1'b0;
    @(posedge clk); #1;
    chk("lit_rst_dp_a", dp_a, 0);
    chk("lit_rst_busy", busy, 0);
    @(posedge clk); #1;
    rstn = 1'b1;
    repeat (12) @(posedge clk); #1;
    chk("lit_rst_no_mv", obs_mc.size(), 0);
    chk("lit_rst_no_done", done_cnt, d0);
    qa = '{4, 5}; qb = '{4, 5};
    start_run(3, 3, 3, 2);
    feed(2, 1'b0);
    wait_done(d0);
    chk("lit_post_rst_done_lat", obs_done_cyc - obs_hs_cyc, 8);
    chk("lit_post_rst_count", obs_mc.size(), 2);

    // Peak magnitude over 5, -300, 12.
    clear_obs(); d0 = done_cnt;
    qa = '{5, -300, 12}; qb = '{1, 1, 1};
    start_run(0, 0, 0, 3);
    feed(3, 1'b0);
    wait_done(d0);
    chk("lit_peak_count", obs_mc.size(), 3);
    if (obs_mc.size() == 3) chk("lit_peak_c1", obs_mc[1], -300);
    chk("lit_peak_at_done", obs_peak_done, PEAK_EN ? 300 : 0);

    repeat (3) @(posedge clk); #1;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

endmodule
